mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single physical-memory port (mem_read / mem_write DPI wrappers) between IFU and LSU.
//  Accepts one request at a time via valid/ready, drives the memory port, and returns a response pulse.
//  Sits between the core front-end/LSU and the memory wrappers. Responses are in order, one outstanding.
// PARAMETERS
//  ADDR_W   64  address width
//  DATA_W   64  data width
//  MEM_LAT  1   cycles the read enable/address are held before rdata is sampled (>=1)
// PORTS
//  clk             in   1       system clock
//  rst_n           in   1       asynchronous active-low reset
//  ifu_req_valid   in   1       IFU read request
//  ifu_req_ready   out  1       IFU request accepted this cycle
//  ifu_addr        in   ADDR_W  IFU read address
//  ifu_resp_valid  out  1       one-cycle pulse: ifu_rdata valid
//  ifu_rdata       out  DATA_W  IFU read data
//  lsu_req_valid   in   1       LSU request
//  lsu_req_ready   out  1       LSU request accepted this cycle
//  lsu_we          in   1       1 = write, 0 = read
//  lsu_addr        in   ADDR_W  LSU address
//  lsu_wdata       in   DATA_W  LSU write data
//  lsu_wmask       in   4       one-hot size: 0001=1B 0010=2B 0100=4B 1000=8B
//  lsu_resp_valid  out  1       one-cycle pulse: read data valid / write done
//  lsu_rdata       out  DATA_W  LSU read data (0 for writes)
//  mem_ren/mem_raddr    out 1/ADDR_W   to mem_read en/addr
//  mem_rdata            in  DATA_W     from mem_read
//  mem_wen/mem_waddr/mem_wdata/mem_wmask  out 1/ADDR_W/DATA_W/4  to mem_write
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, all outputs 0, latched request/rdata cleared, in-flight request dropped with no response.
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if any req_valid, the grant winner sees req_ready=1 (combinational) in the same cycle; request latched; go BUSY with cnt=0.
//    The loser sees ready=0 and must hold valid. req_ready is 0 in BUSY and RESP.
//  - BUSY read: mem_ren=1, mem_raddr=latched addr, for MEM_LAT cycles; at cnt==MEM_LAT-1 sample mem_rdata into rdata reg, go RESP.
//  - BUSY write: mem_wen=1 only in first BUSY cycle (exactly one posedge write), wdata/wmask/waddr forwarded unchanged; still waits MEM_LAT cycles.
//  - RESP: granted requester's resp_valid=1 for exactly one cycle with rdata; other resp_valid=0; return IDLE.
//  - Latency: accept edge to resp_valid = MEM_LAT+1 cycles; max throughput one request per MEM_LAT+2 cycles.
//  - Non-one-hot lsu_wmask forwarded as-is (memory side treats as 8B). No alignment check. cnt width clog2(MEM_LAT+1).
//  - Request arriving in RESP waits for IDLE; never granted in the same cycle as a response.
//  - Rdata regs hold last value between responses; outputs are registered except req_ready.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin on ties; last_grant flop (reset = IFU) -> first tie goes to LSU, then alternate.
//  Not defined: fixed priority, LSU always wins ties (IFU can starve while LSU streams).
// STRUCTURE
//  Shared header mem_arb_defs.vh: state encodings (IDLE/BUSY/RESP), grant IDs (GNT_IFU/GNT_LSU), size codes SZ_B/H/W/D.
//  Sub-module mem_arb_grant: combinational winner select (+ last_grant flop under MEM_ARB_RR_EN).
// TESTING
//  1 IFU read 0x8000_0000, mem returns 0x1122334455667788, MEM_LAT=1 -> ready same cycle, ifu_resp_valid 2 cycles later, rdata match.
//  2 LSU write addr 0x8000_0010 data 0xDEAD wmask 0001 -> mem_wen exactly one cycle, fields forwarded, lsu_resp_valid, lsu_rdata=0.
//  3 Both valid every cycle, RR off -> LSU granted every time, IFU ready never 1; RR on -> LSU,IFU,LSU,IFU grants.
//  4 MEM_LAT=3 read -> mem_ren held 3 cycles with stable addr, resp_valid on 4th cycle after accept.
//  5 rst_n low during BUSY -> all outputs 0 asynchronously, no resp_valid after release, next request served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, grant IDs and size codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_t;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0010;
    localparam logic [3:0] SZ_W = 4'b0100;
    localparam logic [3:0] SZ_D = 4'b1000;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select between IFU and LSU. With MEM_ARB_RR_EN defined, ties alternate via a
// last-grant flop (reset = IFU, so the first tie goes to the LSU); otherwise the LSU always wins.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
    input  logic en,
`endif
    input  logic ifu_valid,
    input  logic lsu_valid,
    output gnt_t winner
);

`ifdef MEM_ARB_RR_EN
    gnt_t last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_IFU;
        end else if (en && (ifu_valid || lsu_valid)) begin
            last_grant <= winner;
        end
    end

    always_comb begin
        winner = GNT_LSU;
        if (ifu_valid && lsu_valid) begin
            winner = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
        end else if (ifu_valid) begin
            winner = GNT_IFU;
        end
    end
`else
    always_comb begin
        winner = GNT_LSU;
        if (ifu_valid && !lsu_valid) begin
            winner = GNT_IFU;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one request in flight, responses in order.
// Tie-break policy selected by MEM_ARB_RR_EN (round-robin) or fixed LSU priority when undefined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    output state_t            dbg_state
);

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // the requester holds valid and payload stable until then. Ready only rises in IDLE.
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    gnt_t             gnt_r;
    logic             we_r;
    gnt_t             winner;
    logic             idle;

    assign idle          = (state == ST_IDLE);
    assign ifu_req_ready = idle && ifu_req_valid && (winner == GNT_IFU);
    assign lsu_req_ready = idle && lsu_req_valid && (winner == GNT_LSU);
    assign dbg_state     = state;

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (idle),
`endif
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .winner    (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            gnt_r          <= GNT_IFU;
            we_r           <= 1'b0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            mem_ren        <= 1'b0;
            mem_raddr      <= '0;
            mem_wen        <= 1'b0;
            mem_waddr      <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lsu_req_ready) begin
                        gnt_r <= GNT_LSU;
                        we_r  <= lsu_we;
                        state <= ST_BUSY;
                        cnt   <= '0;
                        if (lsu_we) begin
                            mem_wen   <= 1'b1;
                            mem_waddr <= lsu_addr;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            mem_ren   <= 1'b1;
                            mem_raddr <= lsu_addr;
                        end
                    end else if (ifu_req_ready) begin
                        gnt_r     <= GNT_IFU;
                        we_r      <= 1'b0;
                        state     <= ST_BUSY;
                        cnt       <= '0;
                        mem_ren   <= 1'b1;
                        mem_raddr <= ifu_addr;
                    end
                end
                ST_BUSY: begin
                    // A write strobes once; the remaining cycles just pace the response.
                    mem_wen <= 1'b0;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MEM_LAT - 1)) begin
                        mem_ren <= 1'b0;
                        state   <= ST_RESP;
                        if (gnt_r == GNT_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= we_r ? '0 : mem_rdata;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    ifu_resp_valid <= 1'b0;
                    lsu_resp_valid <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 3) checked every cycle against a
// transaction-level model (accept cycle + fixed latency), plus hand-computed directed expectations.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam logic [63:0] BASE = 64'h8000_0000;

        logic        rst_n;
        logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
        logic [63:0] ifu_addr, ifu_rdata;
        logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid;
        logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
        logic [3:0]  lsu_wmask, mem_wmask;
        logic        mem_ren, mem_wen;
        logic [63:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
        state_t      dbg_state;
        bit          done = 1'b0;

        mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT)) dut (
            .clk(clk), .rst_n(rst_n),
            .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
            .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
            .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
            .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
            .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
            .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
            .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
            .dbg_state(dbg_state)
        );

        // Memory environment: 16 words at BASE, combinational read.
        logic [63:0] env_mem [16];
        logic [63:0] ref_mem [16];
        logic        mem_load;
        assign mem_rdata = mem_ren ? env_mem[mem_raddr[6:3]] : 64'h0BAD_0BAD_0BAD_0BAD;
        always @(posedge clk) begin
            if (mem_load) env_mem <= ref_mem;
            else if (mem_wen) env_mem[mem_waddr[6:3]] <= mem_wdata;
        end

        // Transaction model: accept at cycle c -> busy c+1..c+LAT, response at c+LAT+1.
        int          cyc, next_free, p_acc;
        bit          p_act, p_lsu, p_wr, last_lsu, hs_i, hs_l;
        logic [63:0] p_addr, p_wdata, p_data, e_ifu_rd, e_lsu_rd;
        logic [3:0]  p_mask;
        bit          gq[$];

        function automatic string nm(string s);
            return $sformatf("L%0d_%s", LAT, s);
        endfunction

        task automatic model_check();
            bit e_ir, e_lr, e_ren, e_wen, e_ird, e_lrd, pick_lsu;
            e_ir = 0; e_lr = 0; e_ren = 0; e_wen = 0; e_ird = 0; e_lrd = 0; pick_lsu = 0;
            if (p_act && cyc >= p_acc + 1 && cyc <= p_acc + LAT) begin
                e_ren = !p_wr;
                e_wen = p_wr && (cyc == p_acc + 1);
            end
            if (p_act && cyc == p_acc + LAT + 1) begin
                if (p_lsu) begin
                    e_lr = 1;
                    e_lsu_rd = p_wr ? 64'h0 : p_data;
                end else begin
                    e_ir = 1;
                    e_ifu_rd = p_data;
                end
                p_act = 0;
            end
            if (cyc >= next_free && (ifu_req_valid || lsu_req_valid)) begin
                if (ifu_req_valid && lsu_req_valid) pick_lsu = RR ? !last_lsu : 1'b1;
                else pick_lsu = lsu_req_valid;
                e_lrd = pick_lsu;
                e_ird = !pick_lsu;
                p_act = 1;
                p_acc = cyc;
                p_lsu = pick_lsu;
                p_wr = pick_lsu && lsu_we;
                p_addr = pick_lsu ? lsu_addr : ifu_addr;
                p_wdata = lsu_wdata;
                p_mask = lsu_wmask;
                p_data = ref_mem[p_addr[6:3]];
                if (p_wr) ref_mem[p_addr[6:3]] = lsu_wdata;
                next_free = cyc + LAT + 2;
                last_lsu = pick_lsu;
            end
            chk(nm("ifu_ready"), ifu_req_ready, e_ird);
            chk(nm("lsu_ready"), lsu_req_ready, e_lrd);
            chk(nm("mem_ren"), mem_ren, e_ren);
            chk(nm("mem_wen"), mem_wen, e_wen);
            chk(nm("ifu_resp"), ifu_resp_valid, e_ir);
            chk(nm("lsu_resp"), lsu_resp_valid, e_lr);
            chk(nm("ifu_rdata"), ifu_rdata, e_ifu_rd);
            chk(nm("lsu_rdata"), lsu_rdata, e_lsu_rd);
            if (e_ren) chk(nm("mem_raddr"), mem_raddr, p_addr);
            if (e_wen) begin
                chk(nm("mem_waddr"), mem_waddr, p_addr);
                chk(nm("mem_wdata"), mem_wdata, p_wdata);
                chk(nm("mem_wmask"), mem_wmask, p_mask);
            end
        endtask

        task automatic model_reset();
            p_act = 0; next_free = 0; e_ifu_rd = 0; e_lsu_rd = 0; last_lsu = 0;
        endtask

        task automatic next_cyc();
            @(posedge clk);
            #1;
            cyc++;
        endtask

        task automatic end_cyc();
            @(negedge clk);
            model_check();
            hs_i = ifu_req_valid && ifu_req_ready;
            hs_l = lsu_req_valid && lsu_req_ready;
        endtask

        task automatic chk_zero(string t);
            chk(nm({t, "_ifu_ready"}), ifu_req_ready, 0);
            chk(nm({t, "_lsu_ready"}), lsu_req_ready, 0);
            chk(nm({t, "_ifu_resp"}), ifu_resp_valid, 0);
            chk(nm({t, "_lsu_resp"}), lsu_resp_valid, 0);
            chk(nm({t, "_ifu_rdata"}), ifu_rdata, 0);
            chk(nm({t, "_lsu_rdata"}), lsu_rdata, 0);
            chk(nm({t, "_mem_ren"}), mem_ren, 0);
            chk(nm({t, "_mem_raddr"}), mem_raddr, 0);
            chk(nm({t, "_mem_wen"}), mem_wen, 0);
            chk(nm({t, "_mem_waddr"}), mem_waddr, 0);
            chk(nm({t, "_mem_wdata"}), mem_wdata, 0);
            chk(nm({t, "_mem_wmask"}), mem_wmask, 0);
            chk(nm({t, "_state"}), dbg_state, 0);
        endtask

        task automatic new_ifu();
            ifu_addr = BASE + 64'($urandom_range(0, 15)) * 8;
        endtask

        task automatic new_lsu();
            lsu_we = 1'($urandom_range(0, 1));
            lsu_addr = BASE + 64'($urandom_range(0, 15)) * 8;
            lsu_wdata = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) lsu_wmask = 4'($urandom_range(0, 15));
            else lsu_wmask = 4'b0001 << $urandom_range(0, 3);
        endtask

        // Requesters hold valid+payload until the transfer edge, then maybe issue anew.
        task automatic traffic(int n, int pct, bit rec);
            repeat (n) begin
                next_cyc();
                if (hs_i) ifu_req_valid = 0;
                if (hs_l) lsu_req_valid = 0;
                if (!ifu_req_valid && $urandom_range(0, 99) < pct) begin
                    ifu_req_valid = 1;
                    new_ifu();
                end
                if (!lsu_req_valid && $urandom_range(0, 99) < pct) begin
                    lsu_req_valid = 1;
                    new_lsu();
                end
                end_cyc();
                if (rec && (hs_i || hs_l)) gq.push_back(hs_l);
            end
        endtask

        task automatic drain();
            traffic(2 * (LAT + 2) + 2, 0, 1'b0);
            hs_i = 0;
            hs_l = 0;
        endtask

        initial begin
            logic [3:0] exp_seq;
            rst_n = 0; mem_load = 1;
            ifu_req_valid = 0; ifu_addr = 0;
            lsu_req_valid = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
            hs_i = 0; hs_l = 0; cyc = 0;
            for (int i = 0; i < 16; i++) ref_mem[i] = {$urandom, $urandom};
            ref_mem[0] = 64'h1122_3344_5566_7788;
            model_reset();
            repeat (2) @(posedge clk);
            #1;
            chk_zero("reset");
            rst_n = 1; mem_load = 0;
            end_cyc();

            // Directed read at BASE: ren held LAT cycles, response LAT+1 cycles after accept.
            next_cyc();
            ifu_req_valid = 1; ifu_addr = BASE;
            end_cyc();
            chk(nm("rd_accept"), ifu_req_ready, 1);
            for (int k = 1; k <= LAT + 1; k++) begin
                next_cyc();
                ifu_req_valid = 0;
                end_cyc();
                if (k <= LAT) begin
                    chk(nm("rd_ren_held"), mem_ren, 1);
                    chk(nm("rd_raddr"), mem_raddr, 64'h8000_0000);
                    chk(nm("rd_no_resp_yet"), ifu_resp_valid, 0);
                end else begin
                    chk(nm("rd_ren_off"), mem_ren, 0);
                    chk(nm("rd_resp"), ifu_resp_valid, 1);
                    chk(nm("rd_data"), ifu_rdata, 64'h1122_3344_5566_7788);
                end
            end
            hs_i = 0;

            // Both requesters always valid: first four grants follow the tie policy.
            gq.delete();
            traffic(4 * (LAT + 2), 100, 1'b1);
            exp_seq = RR ? 4'b0101 : 4'b1111;
            chk(nm("grant_count"), gq.size() >= 4, 1);
            if (gq.size() >= 4)
                for (int k = 0; k < 4; k++) chk(nm($sformatf("grant%0d", k)), gq[k], exp_seq[k]);
            drain();

            traffic(300, 40, 1'b0);
            drain();

            // Directed byte write: one write strobe, fields unchanged, lsu_rdata forced to 0.
            next_cyc();
            lsu_req_valid = 1; lsu_we = 1; lsu_addr = BASE + 64'h10;
            lsu_wdata = 64'hDEAD; lsu_wmask = 4'b0001;
            end_cyc();
            chk(nm("wr_accept"), lsu_req_ready, 1);
            for (int k = 1; k <= LAT + 1; k++) begin
                next_cyc();
                lsu_req_valid = 0;
                end_cyc();
                if (k == 1) begin
                    chk(nm("wr_wen"), mem_wen, 1);
                    chk(nm("wr_waddr"), mem_waddr, 64'h8000_0010);
                    chk(nm("wr_wdata"), mem_wdata, 64'hDEAD);
                    chk(nm("wr_wmask"), mem_wmask, 4'b0001);
                end else begin
                    chk(nm("wr_wen_once"), mem_wen, 0);
                end
                if (k == LAT + 1) begin
                    chk(nm("wr_resp"), lsu_resp_valid, 1);
                    chk(nm("wr_rdata_zero"), lsu_rdata, 0);
                end
            end
            hs_l = 0;

            // Reset while BUSY with an LSU read: outputs clear at once, no late response.
            next_cyc();
            lsu_req_valid = 1; lsu_we = 0; lsu_addr = BASE + 64'h8;
            end_cyc();
            chk(nm("rb_accept"), lsu_req_ready, 1);
            next_cyc();
            lsu_req_valid = 0;
            end_cyc();
            #2;
            rst_n = 0;
            #1;
            chk_zero("async_rst");
            model_reset();
            next_cyc();
            next_cyc();
            rst_n = 1;
            end_cyc();
            hs_i = 0; hs_l = 0;
            traffic(LAT + 3, 0, 1'b0);
            traffic(150, 40, 1'b0);
            drain();
            done = 1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (t < 20000 && !(h[0].done && h[1].done)) begin
            @(posedge clk);
            t++;
        end
        if (!(h[0].done && h[1].done)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d cycles without completion, required done", t);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
